// File: rtl/expr_eval_if.sv
// Character-stream / result bus between the upstream recognizer, expr_eval and the display stage.
interface expr_eval_if #(parameter int W = 16);
  logic         in_valid;
  logic [7:0]   in;
  logic         out;
  logic         err;
  logic [W-1:0] result;
  logic         ovf;

  modport master (output in_valid, in, input out, err, result, ovf);
  modport slave  (input in_valid, in, output out, err, result, ovf);
endinterface

// File: rtl/expr_eval.sv
// Streaming evaluator for "digit ((+|*) digit)*" with '*' binding tighter than '+'.
// Optional sticky overflow detection is built when EXPR_EVAL_OVF_EN is defined.
module expr_eval #(
  parameter int W = 16
) (
  input  logic        clk,
  input  logic        clr,
  expr_eval_if.slave  bus
);

  typedef enum logic [1:0] {S_EXP_DIG, S_EXP_OP, S_ERR} state_t;

  state_t       r_state;
  logic [W-1:0] r_sum;
  logic [W-1:0] r_term;
  logic         r_pend_mul;
  logic [W-1:0] r_result;
  logic         r_out;
  logic         r_err;

  logic         w_is_dig;
  logic [3:0]   w_d;
  logic [W-1:0] w_prod;
  logic [W-1:0] w_new_term;
  logic [W-1:0] w_res;
  logic [W-1:0] w_sum;

  assign w_is_dig   = (bus.in >= 8'h30) && (bus.in <= 8'h39);
  assign w_d        = 4'(bus.in - 8'h30);
  assign w_new_term = r_pend_mul ? w_prod : W'(w_d);

`ifdef EXPR_EVAL_OVF_EN
  // Wide copies keep the bits that fall off the W-bit datapath.
  logic [W+3:0] w_prod_full;
  logic [W:0]   w_res_full;
  logic [W:0]   w_sum_full;
  logic         w_dig_ok;
  logic         w_add_ok;
  logic         r_ovf;

  assign w_prod_full = (W+4)'(r_term) * (W+4)'(w_d);
  assign w_prod      = w_prod_full[W-1:0];
  assign w_res_full  = {1'b0, r_sum} + {1'b0, w_new_term};
  assign w_res       = w_res_full[W-1:0];
  assign w_sum_full  = {1'b0, r_sum} + {1'b0, r_term};
  assign w_sum       = w_sum_full[W-1:0];

  assign w_dig_ok = bus.in_valid && (r_state == S_EXP_DIG) && w_is_dig;
  assign w_add_ok = bus.in_valid && (r_state == S_EXP_OP) && (bus.in == 8'h2B);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_ovf <= 1'b0;
    end else if ((w_dig_ok && ((r_pend_mul && (w_prod_full[W+3:W] != '0)) || w_res_full[W])) ||
                 (w_add_ok && w_sum_full[W])) begin
      r_ovf <= 1'b1;
    end
  end

  assign bus.ovf = r_ovf;
`else
  assign w_prod  = r_term * W'(w_d);
  assign w_res   = r_sum + w_new_term;
  assign w_sum   = r_sum + r_term;
  assign bus.ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= S_EXP_DIG;
      r_sum      <= '0;
      r_term     <= '0;
      r_pend_mul <= 1'b0;
      r_result   <= '0;
      r_out      <= 1'b0;
      r_err      <= 1'b0;
    end else if (bus.in_valid) begin
      case (r_state)
        S_EXP_DIG: begin
          if (w_is_dig) begin
            r_term   <= w_new_term;
            r_result <= w_res;
            r_state  <= S_EXP_OP;
            r_out    <= 1'b1;
          end else begin
            r_state  <= S_ERR;
            r_out    <= 1'b0;
            r_err    <= 1'b1;
          end
        end
        S_EXP_OP: begin
          // result is left alone on operators so it tracks the last complete prefix.
          if (bus.in == 8'h2B) begin
            r_sum      <= w_sum;
            r_pend_mul <= 1'b0;
            r_state    <= S_EXP_DIG;
            r_out      <= 1'b0;
          end else if (bus.in == 8'h2A) begin
            r_pend_mul <= 1'b1;
            r_state    <= S_EXP_DIG;
            r_out      <= 1'b0;
          end else begin
            r_state    <= S_ERR;
            r_out      <= 1'b0;
            r_err      <= 1'b1;
          end
        end
        default: begin
          r_state <= S_ERR;
        end
      endcase
    end
  end

  assign bus.out    = r_out;
  assign bus.err    = r_err;
  assign bus.result = r_result;

endmodule
